// File: rtl/ram_bist_ctrl_if.sv
// rtl/ram_bist_ctrl_if.sv - simple dual-port RAM bus driven by the BIST sequencer
interface ram_bist_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              ram_ena;
  logic              ram_wea;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dina;
  logic              ram_enb;
  logic [ADDR_W-1:0] ram_addrb;
  logic [DATA_W-1:0] ram_doutb;

  modport master (
    output ram_ena, ram_wea, ram_addra, ram_dina, ram_enb, ram_addrb,
    input  ram_doutb
  );

  modport slave (
    input  ram_ena, ram_wea, ram_addra, ram_dina, ram_enb, ram_addrb,
    output ram_doutb
  );
endinterface

// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - write/gap/read-compare BIST sequencer for a simple dual-port RAM
module ram_bist_ctrl #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1,
  parameter int GAP_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  ram_bist_ctrl_if.master   ram
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'((1 << ADDR_W) - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GAP,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;
  logic              pass_q, pass_d;

  logic              vld_pipe_q  [READ_LATENCY];
  logic              vld_pipe_d  [READ_LATENCY];
  logic [DATA_W-1:0] exp_pipe_q  [READ_LATENCY];
  logic [DATA_W-1:0] exp_pipe_d  [READ_LATENCY];
  logic [ADDR_W-1:0] addr_pipe_q [READ_LATENCY];
  logic [ADDR_W-1:0] addr_pipe_d [READ_LATENCY];

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;

  assign cur_addr = cnt_q[ADDR_W-1:0];
  assign cur_data = seed_q + DATA_W'(cur_addr);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seed_d      = seed_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;

    // Expected word travels with the read so it lines up with ram_doutb.
    vld_pipe_d[0]  = (state_q == S_READ) && !abort;
    exp_pipe_d[0]  = cur_data;
    addr_pipe_d[0] = cur_addr;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1] && !abort;
      exp_pipe_d[i]  = exp_pipe_q[i-1];
      addr_pipe_d[i] = addr_pipe_q[i-1];
    end

    if (vld_pipe_q[READ_LATENCY-1] && !abort &&
        (ram.ram_doutb != exp_pipe_q[READ_LATENCY-1])) begin
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      if (err_cnt_q == '0) begin
        first_err_d = addr_pipe_q[READ_LATENCY-1];
      end
    end

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d     = S_WRITE;
            cnt_d       = '0;
            seed_d      = seed;
            err_cnt_d   = '0;
            first_err_d = '0;
          end
        end
        S_WRITE: begin
          if (cnt_q == LAST_ADDR) begin
            state_d = S_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = S_READ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_READ: begin
          if (cnt_q == LAST_ADDR) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    pass_d = (state_d == S_DONE) && (err_cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      seed_q      <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_pipe_q[i]  <= 1'b0;
        exp_pipe_q[i]  <= '0;
        addr_pipe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seed_q      <= seed_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
      vld_pipe_q  <= vld_pipe_d;
      exp_pipe_q  <= exp_pipe_d;
      addr_pipe_q <= addr_pipe_d;
    end
  end

  assign busy           = (state_q == S_WRITE) || (state_q == S_GAP) ||
                          (state_q == S_READ)  || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;

  // Addresses and data are forced to 0 outside their own phase.
  assign ram.ram_ena   = (state_q == S_WRITE);
  assign ram.ram_wea   = (state_q == S_WRITE);
  assign ram.ram_addra = (state_q == S_WRITE) ? cur_addr : '0;
  assign ram.ram_dina  = (state_q == S_WRITE) ? cur_data : '0;
  assign ram.ram_enb   = (state_q == S_READ);
  assign ram.ram_addrb = (state_q == S_READ) ? cur_addr : '0;

endmodule
